// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants.
package riscv_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int PC_INC = 4;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble beats load, otherwise hold.
module if_id_reg #(
   parameter int IW = 32,
   parameter int PW = 32,
   parameter logic [IW-1:0] NOP = riscv_pkg::NOP_INSTR
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          load_i,
   input  logic          bubble_i,
   input  logic [IW-1:0] instr_i,
   input  logic [PW-1:0] pc_i,
   output logic [IW-1:0] instr_o,
   output logic [PW-1:0] pc_o,
   output logic          valid_o
);
   logic [IW-1:0] instr_q;
   logic [PW-1:0] pc_q;
   logic          valid_q;
   always_ff @(posedge clk) begin
      if (!rstN) begin
         instr_q <= NOP;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (bubble_i) begin
         instr_q <= NOP;
         pc_q    <= pc_i;
         valid_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         valid_q <= 1'b1;
      end
   end
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, run control and IF/ID capture for an async instruction memory.
// Define FETCH_PERF_CNT_EN to add fetch_count/bubble_count outputs.
module fetch_unit #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic                         clk,
   input  logic                         rstN,
   input  logic                         start,
   input  logic                         halt,
   input  logic                         stall,
   input  logic                         redirect,
   input  logic [PC_WIDTH-1:0]          redirect_target,
   output logic [PC_WIDTH-1:0]          imem_address,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
   output logic [INSTRUCTION_WIDTH-1:0] if_id_instr,
   output logic [PC_WIDTH-1:0]          if_id_pc,
   output logic                         if_id_valid,
   output logic                         running,
   output logic                         misaligned_err
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                  fetch_count,
   output logic [31:0]                  bubble_count
`endif
);
   import riscv_pkg::*;
   fetch_state_t state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic err_q, err_d;
   logic run, go, do_halt, do_redir, do_fetch, bubble;
   always_comb begin
      run      = state_q == RUN;
      go       = !run && start;
      do_halt  = run && halt;
      do_redir = run && !halt && redirect;
      do_fetch = run && !halt && !redirect && !stall;
      bubble   = !run || do_halt || do_redir;
      state_d  = go ? RUN : do_halt ? HALT : state_q;
      pc_d     = go ? RESET_VECTOR
               : do_redir ? {redirect_target[PC_WIDTH-1:2], 2'b00}
               : do_fetch ? pc_q + PC_WIDTH'(PC_INC) : pc_q;
      err_d    = err_q | (do_redir && |redirect_target[1:0]);
   end
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
      end
   end
   if_id_reg #(.IW(INSTRUCTION_WIDTH), .PW(PC_WIDTH), .NOP(NOP_INSTR)) u_if_id (
      .clk(clk), .rstN(rstN), .load_i(do_fetch), .bubble_i(bubble),
      .instr_i(imem_instruction), .pc_i(pc_q),
      .instr_o(if_id_instr), .pc_o(if_id_pc), .valid_o(if_id_valid)
   );
   assign imem_address   = pc_q;
   assign running        = run;
   assign misaligned_err = err_q;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fcnt_q, bcnt_q;
   always_ff @(posedge clk) begin
      if (!rstN) begin
         fcnt_q <= '0;
         bcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + {31'd0, do_fetch};
         bcnt_q <= bcnt_q + {31'd0, do_halt || do_redir};
      end
   end
   assign fetch_count  = fcnt_q;
   assign bubble_count = bcnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus against an in-bench fetch model.
module tb_fetch_unit;
   logic clk = 0, rstN = 0, start = 0, halt = 0, stall = 0, redirect = 0;
   logic [31:0] redirect_target = 0, imem_address, imem_instruction;
   logic [31:0] if_id_instr, if_id_pc;
   logic if_id_valid, running, misaligned_err;
   logic [31:0] mem [256];
   int checks = 0, errors = 0;
   int m_state;
   logic [31:0] m_pc, m_instr, m_ipc;
   logic m_valid, m_err;
   logic [31:0] m_fc, m_bc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, bubble_count;
`endif
   always #5 clk = ~clk;
   assign imem_instruction = mem[imem_address[9:2]];
   fetch_unit dut (
      .clk(clk), .rstN(rstN), .start(start), .halt(halt), .stall(stall),
      .redirect(redirect), .redirect_target(redirect_target),
      .imem_address(imem_address), .imem_instruction(imem_instruction),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
      .running(running), .misaligned_err(misaligned_err)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic bubble_m();
      m_instr = 32'h13;
      m_ipc   = m_pc;
      m_valid = 0;
   endtask
   // 0=IDLE 1=RUN 2=HALT; advances one edge using the inputs currently applied
   task automatic model_step();
      logic [31:0] fetched;
      fetched = mem[m_pc[9:2]];
      if (!rstN) begin
         m_state = 0; m_pc = 0; m_instr = 32'h13; m_ipc = 0; m_valid = 0;
         m_err = 0; m_fc = 0; m_bc = 0;
      end else if (m_state != 1) begin
         bubble_m();
         if (start) begin m_state = 1; m_pc = 0; end
      end else if (halt) begin
         bubble_m(); m_state = 2; m_bc++;
      end else if (redirect) begin
         bubble_m(); m_bc++;
         m_pc = redirect_target & ~32'd3;
         if (redirect_target % 4 != 0) m_err = 1;
      end else if (!stall) begin
         m_instr = fetched; m_ipc = m_pc; m_valid = 1;
         m_pc = m_pc + 4; m_fc++;
      end
   endtask
   task automatic compare();
      chk("imem_address", imem_address, m_pc);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      chk("running", {31'd0, running}, {31'd0, m_state == 1});
      chk("misaligned_err", {31'd0, misaligned_err}, {31'd0, m_err});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fc);
      chk("bubble_count", bubble_count, m_bc);
`endif
   endtask
   task automatic cycle(input logic r, input logic s, input logic h, input logic st,
                        input logic rd, input logic [31:0] tgt);
      @(negedge clk);
      rstN = r; start = s; halt = h; stall = st; redirect = rd; redirect_target = tgt;
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask
   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'hA000_000A; mem[1] = 32'hB000_000B;
      mem[2] = 32'hC000_000C; mem[3] = 32'hD000_000D;
      mem[16] = 32'hE000_000E;
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      chk("lit_reset_instr", if_id_instr, 32'h0000_0013);
      chk("lit_reset_pc", imem_address, 32'h0);
      cycle(1, 0, 0, 1, 1, 32'h80);
      chk("lit_idle_ignores_redirect", imem_address, 32'h0);
      cycle(1, 1, 0, 0, 0, 0);
      chk("lit_running", {31'd0, running}, 32'd1);
      chk("lit_first_run_valid", {31'd0, if_id_valid}, 32'd0);
      run_n(2);
      chk("lit_B", if_id_instr, 32'hB000_000B);
      chk("lit_pc8", imem_address, 32'h8);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 0, 1, 0, 0);
         chk("lit_stall_hold_pc", if_id_pc, 32'h4);
      end
      run_n(1);
      chk("lit_C", if_id_instr, 32'hC000_000C);
      cycle(1, 0, 0, 1, 1, 32'h40);
      chk("lit_redir_pc", imem_address, 32'h40);
      chk("lit_redir_bubble", if_id_instr, 32'h0000_0013);
      run_n(1);
      chk("lit_E", if_id_instr, 32'hE000_000E);
      cycle(1, 0, 0, 0, 1, 32'h42);
      chk("lit_misalign_pc", imem_address, 32'h40);
      chk("lit_misalign_err", {31'd0, misaligned_err}, 32'd1);
      cycle(1, 0, 0, 0, 1, 32'h10);
      cycle(1, 0, 1, 1, 1, 32'h80);
      chk("lit_halt_pc", imem_address, 32'h10);
      chk("lit_halt_running", {31'd0, running}, 32'd0);
      cycle(1, 0, 0, 1, 1, 32'h80);
      cycle(1, 1, 0, 0, 0, 0);
      chk("lit_restart_pc", imem_address, 32'h0);
      cycle(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
      run_n(1);
      chk("lit_wrap_pc", imem_address, 32'h0);
      chk("lit_err_sticky", {31'd0, misaligned_err}, 32'd1);
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 1023)));
      cycle(1, 1, 0, 0, 0, 0);
      run_n(2);
      cycle(0, 0, 0, 1, 1, 32'h43);
      chk("lit_rst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("lit_rst_err", {31'd0, misaligned_err}, 32'd0);
      chk("lit_rst_ifpc", if_id_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("lit_rst_fcnt", fetch_count, 32'h0);
      chk("lit_rst_bcnt", bubble_count, 32'h0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
